// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS).
// One transaction in flight at a time; LS has priority, IF is protected from starvation.
module mem_port_arbiter #(
   parameter int XLEN       = 32,
   parameter int LATENCY    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_req,
   input  logic [XLEN-1:0] if_addr,
   input  logic            if_flush,
   output logic            if_gnt,
   output logic            if_rvalid,
   output logic [XLEN-1:0] if_rdata,
   input  logic            ls_req,
   input  logic            ls_we,
   input  logic [XLEN-1:0] ls_addr,
   input  logic [XLEN-1:0] ls_wdata,
   input  logic [3:0]      ls_be,
   output logic            ls_gnt,
   output logic            ls_rvalid,
   output logic [XLEN-1:0] ls_rdata,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [3:0]      mem_be,
   input  logic [XLEN-1:0] mem_rdata
);

   localparam int CW = $clog2(LATENCY + 1);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(LATENCY);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          owner_if_q, owner_if_d;
   logic          drop_q, drop_d;
   logic          if_elig;
   logic          if_wins;
   logic          ls_wins;
   logic          if_deliver;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         starve_q   <= '0;
         owner_if_q <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         starve_q   <= starve_d;
         owner_if_q <= owner_if_d;
         drop_q     <= drop_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      starve_d   = starve_q;
      owner_if_d = owner_if_q;
      drop_d     = drop_q;
      if_elig    = if_req & ~if_flush;
      if_wins    = 1'b0;
      ls_wins    = 1'b0;
      if_deliver = 1'b0;
      if_gnt     = 1'b0;
      if_rvalid  = 1'b0;
      if_rdata   = '0;
      ls_gnt     = 1'b0;
      ls_rvalid  = 1'b0;
      ls_rdata   = '0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_be     = 4'h0;

      // Outputs are forced quiet while reset is held, even if requests are pending.
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (if_elig && (!ls_req || starve_q == STARVE_LIM)) begin
                  if_wins = 1'b1;
               end else if (ls_req) begin
                  ls_wins = 1'b1;
               end

               if (if_wins) begin
                  mem_req    = 1'b1;
                  mem_addr   = if_addr;
                  mem_be     = 4'hF;
                  starve_d   = '0;
                  owner_if_d = 1'b1;
               end else if (ls_wins) begin
                  mem_req    = 1'b1;
                  mem_we     = ls_we;
                  mem_addr   = ls_addr;
                  mem_wdata  = ls_wdata;
                  mem_be     = ls_be;
                  owner_if_d = 1'b0;
                  if (!if_req) begin
                     starve_d = '0;
                  end else if (starve_q != STARVE_LIM) begin
                     starve_d = starve_q + SW'(1);
                  end
               end else if (!if_req) begin
                  starve_d = '0;
               end

               if_gnt = if_wins;
               ls_gnt = ls_wins;
               if (if_wins || ls_wins) begin
                  state_d = WAIT;
                  cnt_d   = CW'(1);
                  drop_d  = 1'b0;
               end
            end

            WAIT: begin
               if (owner_if_q && if_flush) begin
                  drop_d = 1'b1;
               end
               // A flush arriving in the completion cycle still kills the fetch data.
               if (cnt_q == CNT_LAST) begin
                  if (owner_if_q) begin
                     if_deliver = ~drop_q & ~if_flush;
                     if_rvalid  = if_deliver;
                     if_rdata   = if_deliver ? mem_rdata : '0;
                  end else begin
                     ls_rvalid = 1'b1;
                     ls_rdata  = mem_rdata;
                  end
                  state_d = IDLE;
                  cnt_d   = '0;
                  drop_d  = 1'b0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one instance at LATENCY=1 and one at LATENCY=3,
// driven from shared inputs; the monitor checks whichever instance is selected.
module tb_mem_port_arbiter;

   typedef struct packed {
      logic        is_if;
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  be;
   } gnt_t;

   typedef struct packed {
      logic        is_if;
      logic [31:0] data;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_flush, ls_req, ls_we;
   logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
   logic [3:0]  ls_be;
   logic        sel;

   logic        a_if_gnt, a_if_rvalid, a_ls_gnt, a_ls_rvalid, a_mem_req, a_mem_we;
   logic [31:0] a_if_rdata, a_ls_rdata, a_mem_addr, a_mem_wdata;
   logic [3:0]  a_mem_be;
   logic        b_if_gnt, b_if_rvalid, b_ls_gnt, b_ls_rvalid, b_mem_req, b_mem_we;
   logic [31:0] b_if_rdata, b_ls_rdata, b_mem_addr, b_mem_wdata;
   logic [3:0]  b_mem_be;

   logic        m_if_gnt, m_if_rvalid, m_ls_gnt, m_ls_rvalid, m_mem_req, m_mem_we;
   logic [31:0] m_if_rdata, m_ls_rdata, m_mem_addr, m_mem_wdata;
   logic [3:0]  m_mem_be;

   gnt_t gnt_q[$];
   rsp_t rsp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   issue_cyc = 0;
   bit   mon_en = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   mem_port_arbiter #(.XLEN(32), .LATENCY(1), .STARVE_MAX(4)) u_lat1 (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
      .ls_gnt(a_ls_gnt), .ls_rvalid(a_ls_rvalid), .ls_rdata(a_ls_rdata),
      .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
      .mem_wdata(a_mem_wdata), .mem_be(a_mem_be), .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.XLEN(32), .LATENCY(3), .STARVE_MAX(4)) u_lat3 (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
      .ls_gnt(b_ls_gnt), .ls_rvalid(b_ls_rvalid), .ls_rdata(b_ls_rdata),
      .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_be(b_mem_be), .mem_rdata(mem_rdata)
   );

   assign m_if_gnt    = sel ? b_if_gnt    : a_if_gnt;
   assign m_if_rvalid = sel ? b_if_rvalid : a_if_rvalid;
   assign m_if_rdata  = sel ? b_if_rdata  : a_if_rdata;
   assign m_ls_gnt    = sel ? b_ls_gnt    : a_ls_gnt;
   assign m_ls_rvalid = sel ? b_ls_rvalid : a_ls_rvalid;
   assign m_ls_rdata  = sel ? b_ls_rdata  : a_ls_rdata;
   assign m_mem_req   = sel ? b_mem_req   : a_mem_req;
   assign m_mem_we    = sel ? b_mem_we    : a_mem_we;
   assign m_mem_addr  = sel ? b_mem_addr  : a_mem_addr;
   assign m_mem_wdata = sel ? b_mem_wdata : a_mem_wdata;
   assign m_mem_be    = sel ? b_mem_be    : a_mem_be;

   task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s @cyc %0d: got timeout/unexpected expected event", name, cyc);
   endtask

   task automatic check_all_zero(input string name);
      check_output(name,
         {m_if_gnt, m_ls_gnt, m_if_rvalid, m_ls_rvalid, m_mem_req, m_mem_we, m_mem_be,
          m_mem_addr, m_mem_wdata, m_if_rdata, m_ls_rdata}, '0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the scoreboard whenever the selected DUT grants or responds.
   always @(negedge clk) begin
      gnt_t g;
      rsp_t r;
      int   lat;
      if (!rst && mon_en) begin
         lat = sel ? 3 : 1;
         check_output("mem_req_vs_gnt", {127'd0, m_mem_req}, {127'd0, m_if_gnt | m_ls_gnt});
         if (m_if_gnt || m_ls_gnt) begin
            if (gnt_q.size() == 0) begin
               fail_now("unexpected_gnt");
            end else begin
               g = gnt_q.pop_front();
               check_output("grant",
                  {m_if_gnt, m_ls_gnt, m_mem_we, m_mem_addr,
                   g.is_if ? g.be : m_mem_be, (g.is_if || !g.we) ? g.wdata : m_mem_wdata},
                  {g.is_if, ~g.is_if, g.we, g.addr, g.be, g.wdata});
            end
            issue_cyc = cyc;
         end
         if (m_if_rvalid || m_ls_rvalid) begin
            if (rsp_q.size() == 0) begin
               fail_now("unexpected_rvalid");
            end else begin
               r = rsp_q.pop_front();
               check_output("response",
                  {m_if_rvalid, m_ls_rvalid, r.is_if ? m_if_rdata : m_ls_rdata},
                  {r.is_if, ~r.is_if, r.data});
               check_output("resp_latency", 128'(cyc - issue_cyc), 128'(lat));
            end
         end
         check_output("idle_rdata_zero",
            {m_if_rvalid ? 32'd0 : m_if_rdata, m_ls_rvalid ? 32'd0 : m_ls_rdata}, '0);
      end
   end

   task automatic wait_gnt(input bit is_if, output int gcyc);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      gcyc = -1;
      while (!seen && n < 20) begin
         @(negedge clk);
         seen = is_if ? m_if_gnt : m_ls_gnt;
         n++;
      end
      if (seen) gcyc = cyc;
      else fail_now(is_if ? "if_gnt_timeout" : "ls_gnt_timeout");
   endtask

   // Issues one request, holding it until granted, then drops req in the next cycle.
   task automatic apply_stimulus(input bit is_if, input logic [31:0] addr, input bit we,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 input bit expect_rsp, output int gcyc);
      gnt_t g;
      rsp_t r;
      g.is_if = is_if;
      g.addr  = addr;
      g.we    = is_if ? 1'b0 : we;
      g.wdata = (is_if || !we) ? 32'd0 : wdata;
      g.be    = be;
      gnt_q.push_back(g);
      if (expect_rsp) begin
         r.is_if = is_if;
         r.data  = mem_rdata;
         rsp_q.push_back(r);
      end
      if (is_if) begin
         if_req  = 1'b1;
         if_addr = addr;
      end else begin
         ls_req   = 1'b1;
         ls_we    = we;
         ls_addr  = addr;
         ls_wdata = wdata;
         ls_be    = be;
      end
      wait_gnt(is_if, gcyc);
      tick();
      if (is_if) if_req = 1'b0;
      else ls_req = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((gnt_q.size() != 0 || rsp_q.size() != 0) && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) fail_now("drain_timeout");
      repeat (5) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      if_req = 1'b1;
      ls_req = 1'b1;
      @(negedge clk);
      check_all_zero("outputs_in_reset");
      tick();
      if_req = 1'b0;
      ls_req = 1'b0;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("outputs_after_reset");
      tick();
   endtask

   initial begin
      int t0, t1, got, n;
      rsp_t r;
      gnt_t g;
      rst = 1'b1; sel = 1'b0;
      if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
      ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_be = '0;
      mem_rdata = '0;
      tick();

      // ---------------- LATENCY = 1 ----------------
      do_reset();
      mon_en = 1'b1;

      mem_rdata = 32'hDEADBEEF;
      apply_stimulus(1'b1, 32'h100, 1'b0, '0, 4'hF, 1'b1, t0);
      drain();

      mem_rdata = 32'h12345678;
      apply_stimulus(1'b0, 32'h2000, 1'b1, 32'h55AA, 4'hF, 1'b1, t0);
      drain();

      mem_rdata = 32'hCAFEF00D;
      apply_stimulus(1'b0, 32'h3000, 1'b0, '0, 4'h3, 1'b1, t0);
      drain();

      // Both requesting continuously: LS x4, IF, LS x4, IF.
      mem_rdata = 32'h0BADC0DE;
      for (int i = 0; i < 10; i++) begin
         g.is_if = (i == 4 || i == 9);
         g.addr  = g.is_if ? 32'h400 : 32'h800;
         g.we    = 1'b0;
         g.wdata = '0;
         g.be    = 4'hF;
         gnt_q.push_back(g);
         r.is_if = g.is_if;
         r.data  = mem_rdata;
         rsp_q.push_back(r);
      end
      if_req = 1'b1; if_addr = 32'h400;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h800; ls_be = 4'hF;
      got = 0;
      n = 0;
      while (got < 10 && n < 100) begin
         @(negedge clk);
         if (m_if_gnt || m_ls_gnt) got++;
         n++;
      end
      if (got < 10) fail_now("starve_seq_timeout");
      tick();
      if_req = 1'b0;
      ls_req = 1'b0;
      drain();

      // Flushing IF is not eligible in IDLE; LS still wins.
      if_req = 1'b1; if_flush = 1'b1; if_addr = 32'h123;
      repeat (3) tick();
      mem_rdata = 32'h0F0F0F0F;
      apply_stimulus(1'b0, 32'h3100, 1'b0, '0, 4'hF, 1'b1, t0);
      if_req = 1'b0; if_flush = 1'b0;
      drain();

      // ---------------- LATENCY = 3 ----------------
      mon_en = 1'b0;
      sel = 1'b1;
      do_reset();
      mon_en = 1'b1;

      mem_rdata = 32'hA5A5A5A5;
      apply_stimulus(1'b1, 32'h480, 1'b0, '0, 4'hF, 1'b1, t0);
      drain();

      // Flush one cycle after issue: fetch dropped, next IF grant at T+4.
      mem_rdata = 32'h22222222;
      apply_stimulus(1'b1, 32'h500, 1'b0, '0, 4'hF, 1'b0, t0);
      if_flush = 1'b1;
      tick();
      if_flush = 1'b0;
      apply_stimulus(1'b1, 32'h600, 1'b0, '0, 4'hF, 1'b1, t1);
      check_output("regrant_after_flush", 128'(t1 - t0), 128'd4);
      drain();

      // Flush in the completion cycle only.
      apply_stimulus(1'b1, 32'h700, 1'b0, '0, 4'hF, 1'b0, t0);
      tick();
      tick();
      if_flush = 1'b1;
      tick();
      if_flush = 1'b0;
      drain();

      // Flush during an LS-owned transaction is ignored.
      mem_rdata = 32'h33333333;
      apply_stimulus(1'b0, 32'h900, 1'b0, '0, 4'hF, 1'b1, t0);
      if_flush = 1'b1;
      repeat (3) tick();
      if_flush = 1'b0;
      drain();

      // Reset mid-WAIT abandons the load; a fresh load afterwards completes.
      apply_stimulus(1'b0, 32'hA00, 1'b0, '0, 4'hF, 1'b0, t0);
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("outputs_reset_mid_wait");
      tick();
      rst = 1'b0;
      repeat (5) tick();
      mem_rdata = 32'h44444444;
      apply_stimulus(1'b0, 32'hB00, 1'b0, '0, 4'hF, 1'b1, t0);
      drain();

      check_output("gnt_queue_empty", 128'(gnt_q.size()), 128'd0);
      check_output("rsp_queue_empty", 128'(rsp_q.size()), 128'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
